// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the issue, load, function-unit and debug signals of alu_issue_ctrl.
// master = the controller, slave = the instruction source / function units.
interface alu_issue_ctrl_if;
    logic       ld_valid;
    logic [1:0] ld_addr;
    logic [3:0] ld_data;
    logic       instr_valid;
    logic       instr_ready;
    logic [1:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs1;
    logic [1:0] instr_rs2;
    logic [3:0] op_en;
    logic [3:0] Rd1;
    logic [3:0] Rd2;
    logic [3:0] result;
    logic       done;
    logic       zero;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    modport master (
        input  ld_valid, ld_addr, ld_data,
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        output instr_ready,
        output op_en, Rd1, Rd2,
        input  result,
        output done, zero,
        input  dbg_addr,
        output dbg_data
    );

    modport slave (
        output ld_valid, ld_addr, ld_data,
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2,
        input  instr_ready,
        input  op_en, Rd1, Rd2,
        output result,
        input  done, zero,
        output dbg_addr,
        input  dbg_data
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller for 4-bit logic units: 4x4 register file, one instruction
// in flight (IDLE->READ->EXEC->WB). Optional zero flag enabled by ALU_ISSUE_ZERO_FLAG_EN.
module alu_issue_ctrl (
    input logic                clk,
    input logic                rst,
    alu_issue_ctrl_if.master   bus
);

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;

    state_e     state_q, state_d;
    logic [3:0] rf_q [4];
    logic [3:0] rf_d [4];
    logic [1:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [1:0] rs1_q, rs1_d;
    logic [1:0] rs2_q, rs2_d;
    logic [3:0] opa_q, opa_d;
    logic [3:0] opb_q, opb_d;
    logic [3:0] res_q, res_d;

    always_comb begin
        state_d         = state_q;
        rf_d            = rf_q;
        op_d            = op_q;
        rd_d            = rd_q;
        rs1_d           = rs1_q;
        rs2_d           = rs2_q;
        opa_d           = opa_q;
        opb_d           = opb_q;
        res_d           = res_q;
        bus.instr_ready = 1'b0;
        bus.op_en       = 4'b0000;
        bus.Rd1         = 4'h0;
        bus.Rd2         = 4'h0;
        bus.done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Loads win over instructions; the instruction simply waits a cycle.
                bus.instr_ready = ~bus.ld_valid & ~rst;
                if (bus.ld_valid) begin
                    rf_d[bus.ld_addr] = bus.ld_data;
                end else if (bus.instr_valid && bus.instr_ready) begin
                    op_d    = bus.instr_op;
                    rd_d    = bus.instr_rd;
                    rs1_d   = bus.instr_rs1;
                    rs2_d   = bus.instr_rs2;
                    state_d = StRead;
                end
            end
            StRead: begin
                opa_d   = rf_q[rs1_q];
                opb_d   = rf_q[rs2_q];
                state_d = StExec;
            end
            StExec: begin
                // Units present 4'h0 when disabled, so only the enabled one shows on result.
                bus.op_en = 4'b0001 << op_q;
                bus.Rd1   = opa_q;
                bus.Rd2   = opb_q;
                res_d     = bus.result;
                state_d   = StWb;
            end
            StWb: begin
                rf_d[rd_q] = res_q;
                bus.done   = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            rf_q    <= '{default: 4'h0};
            op_q    <= 2'd0;
            rd_q    <= 2'd0;
            rs1_q   <= 2'd0;
            rs2_q   <= 2'd0;
            opa_q   <= 4'h0;
            opb_q   <= 4'h0;
            res_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            rf_q    <= rf_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
        end
    end

    assign bus.dbg_data = rf_q[bus.dbg_addr];

`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic zero_q, zero_d;

    always_comb begin
        zero_d = zero_q;
        if (state_q == StWb) begin
            zero_d = (res_q == 4'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.zero = zero_q;
`else
    assign bus.zero = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_alu_issue_ctrl;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Function-unit models: each outputs 0 when disabled, outputs OR-ed together.
    assign bus.result = (bus.op_en[0] ? (bus.Rd1 & bus.Rd2)    : 4'h0) |
                        (bus.op_en[1] ? (bus.Rd1 | bus.Rd2)    : 4'h0) |
                        (bus.op_en[2] ? ~(bus.Rd1 & bus.Rd2)   : 4'h0) |
                        (bus.op_en[3] ? (bus.Rd1 ^ bus.Rd2)    : 4'h0);

    typedef struct {
        logic [1:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input logic [1:0] addr, input logic [3:0] exp, input string name);
        bus.dbg_addr = addr;
        #1;
        chk(name, bus.dbg_data, exp);
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [1:0] rd,
                             input logic [1:0] rs1, input logic [1:0] rs2);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_rs1   = rs1;
        bus.instr_rs2   = rs2;
    endtask

    task automatic run_vec(input vec_t v);
        load(v.rs1, v.a);
        if (v.rs2 != v.rs1) load(v.rs2, v.b);
        set_instr(v.op, v.rd, v.rs1, v.rs2);
        #1;
        chk("vec_ready_idle", bus.instr_ready, 1);
        tick();                                   // cycle 1: READ
        bus.instr_valid = 1'b0;
        chk("vec_ready_read", bus.instr_ready, 0);
        chk("vec_open_read", bus.op_en, 0);
        tick();                                   // cycle 2: EXEC
        chk("vec_op_en", bus.op_en, 4'b0001 << v.op);
        chk("vec_rd1", bus.Rd1, v.a);
        chk("vec_rd2", bus.Rd2, v.b);
        chk("vec_done_exec", bus.done, 0);
        tick();                                   // cycle 3: WB
        chk("vec_done_wb", bus.done, 1);
        chk("vec_open_wb", bus.op_en, 0);
        chk("vec_rd1_wb", bus.Rd1, 0);
        tick();                                   // cycle 4: IDLE
        chk("vec_done_after", bus.done, 0);
        chk("vec_ready_after", bus.instr_ready, 1);
        chk_reg(v.rd, v.exp, "vec_wb_value");
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        chk("vec_zero", bus.zero, (v.exp == 4'h0));
`else
        chk("vec_zero_tied", bus.zero, 0);
`endif
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        vecs[0] = '{op: 2'b10, rd: 2'd3, rs1: 2'd1, rs2: 2'd2, a: 4'hC, b: 4'hA, exp: 4'h7};
        vecs[1] = '{op: 2'b00, rd: 2'd0, rs1: 2'd1, rs2: 2'd2, a: 4'h5, b: 4'hA, exp: 4'h0};
        vecs[2] = '{op: 2'b01, rd: 2'd3, rs1: 2'd1, rs2: 2'd2, a: 4'h5, b: 4'hA, exp: 4'hF};
        vecs[3] = '{op: 2'b11, rd: 2'd1, rs1: 2'd1, rs2: 2'd1, a: 4'h9, b: 4'h9, exp: 4'h0};
        vecs[4] = '{op: 2'b11, rd: 2'd0, rs1: 2'd2, rs2: 2'd3, a: 4'h6, b: 4'h3, exp: 4'h5};
        vecs[5] = '{op: 2'b00, rd: 2'd2, rs1: 2'd2, rs2: 2'd3, a: 4'hE, b: 4'h7, exp: 4'h6};

        rst             = 1'b1;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = 2'd0;
        bus.ld_data     = 4'h0;
        bus.instr_valid = 1'b0;
        bus.instr_op    = 2'd0;
        bus.instr_rd    = 2'd0;
        bus.instr_rs1   = 2'd0;
        bus.instr_rs2   = 2'd0;
        bus.dbg_addr    = 2'd0;

        // Reset
        tick();
        tick();
        chk("rst_op_en", bus.op_en, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_zero", bus.zero, 0);
        for (int i = 0; i < 4; i++) chk_reg(i[1:0], 4'h0, "rst_reg");
        rst = 1'b0;
        #1;
        chk("rst_ready_after", bus.instr_ready, 1);
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Back-to-back: XOR r0 = r1 ^ r2, then AND r3 = r0 & r1, valid held throughout
        load(2'd1, 4'h3);
        load(2'd2, 4'h5);
        set_instr(2'b11, 2'd0, 2'd1, 2'd2);
        #1;
        chk("b2b_ready0", bus.instr_ready, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int c = 1; c <= 3; c++) begin
                chk("b2b_ready_busy", bus.instr_ready, 0);
                tick();
            end
            chk("b2b_ready_again", bus.instr_ready, 1);
            if (k == 0) begin
                chk_reg(2'd0, 4'h6, "b2b_xor");
                set_instr(2'b00, 2'd3, 2'd0, 2'd1);
            end else begin
                bus.instr_valid = 1'b0;
                chk_reg(2'd3, 4'h2, "b2b_and");
            end
        end

        // Load/instruction collision; plus a load during READ that must be dropped
        bus.ld_valid = 1'b1;
        bus.ld_addr  = 2'd1;
        bus.ld_data  = 4'h9;
        set_instr(2'b01, 2'd2, 2'd1, 2'd1);
        #1;
        chk("col_ready_low", bus.instr_ready, 0);
        tick();
        bus.ld_valid = 1'b0;
        #1;
        chk("col_ready_next", bus.instr_ready, 1);
        tick();                                   // READ
        bus.instr_valid = 1'b0;
        bus.ld_valid    = 1'b1;
        bus.ld_addr     = 2'd3;
        bus.ld_data     = 4'hF;
        tick();                                   // EXEC
        bus.ld_valid = 1'b0;
        chk("col_rd1_new", bus.Rd1, 4'h9);
        tick();                                   // WB
        tick();                                   // IDLE
        chk_reg(2'd2, 4'h9, "col_result");
        chk_reg(2'd3, 4'h2, "col_ld_dropped");

        // Reset during EXEC aborts the instruction
        set_instr(2'b00, 2'd1, 2'd2, 2'd2);
        tick();                                   // READ
        bus.instr_valid = 1'b0;
        tick();                                   // EXEC
        chk("rex_op_en", bus.op_en, 4'b0001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rex_done", bus.done, 0);
        chk("rex_op_en_after", bus.op_en, 0);
        chk("rex_ready", bus.instr_ready, 1);
        chk_reg(2'd1, 4'h0, "rex_dest");
        tick();
        chk("rex_done_late", bus.done, 0);
        chk_reg(2'd1, 4'h0, "rex_dest_late");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue/write-back controller sitting on the initiator side of the 4-bit logic-unit interface. Holds a 4-entry × 4-bit register file, accepts one instruction at a time, and reads two source registers onto `Rd1`/`Rd2`. It asserts exactly one function-unit enable and writes the returned `result` back to the destination register. Each function unit outputs 4'h0 when disabled, so their outputs are OR-ed externally onto the single `result` input.

## Interface
Parameters:
- none; data width fixed at 4, register count fixed at 4

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `ld_valid`  in  1  direct register load request
- `ld_addr`  in  2  load destination register
- `ld_data`  in  4  load value
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  controller can accept an instruction
- `instr_op`  in  2  operation: 00 AND, 01 OR, 10 NAND, 11 XOR
- `instr_rd`  in  2  destination register
- `instr_rs1`  in  2  source register 1
- `instr_rs2`  in  2  source register 2
- `op_en`  out  4  one-hot function-unit enable, bit index = `instr_op`
- `Rd1`  out  4  operand 1 to function units
- `Rd2`  out  4  operand 2 to function units
- `result`  in  4  OR of all function-unit outputs
- `done`  out  1  one-cycle pulse on write-back
- `zero`  out  1  last written-back result was 4'h0
- `dbg_addr`  in  2  debug read address
- `dbg_data`  out  4  combinational read of register `dbg_addr`

## Operation
- States:
  - IDLE: `instr_ready` = 1 unless `ld_valid` = 1.
  - READ: latch instruction-selected operands.
  - EXEC: drive units, sample `result`.
  - WB: write destination register.
- Transitions:
  - IDLE → READ on `instr_valid & instr_ready`; latch op, rd, rs1, rs2.
  - READ → EXEC → WB → IDLE unconditionally.
- Loads:
  - `ld_valid` in IDLE writes `ld_data` to `ld_addr` at that edge.
  - A load has priority over an instruction: with both high, the load completes and the instruction waits.
  - `ld_valid` outside IDLE is ignored (dropped).
- READ: operand registers ← reg[rs1], reg[rs2]. Sources may alias each other or rd.
- EXEC:
  - `op_en` = one-hot(op); `Rd1`/`Rd2` = latched operands.
  - `result` is captured into the result register at the end of EXEC.
- WB: reg[rd] ← captured result; `done` = 1.
- Outside EXEC: `op_en` = 4'b0000 and `Rd1` = `Rd2` = 4'h0, so disabled units present 4'h0.
- `instr_ready` is 0 in READ, EXEC and WB. Only one instruction is in flight; there are no data hazards.
- Reset values:
  - state IDLE, all registers 4'h0
  - `op_en` 0, `Rd1`/`Rd2` 0
  - `done` 0, `zero` 0
  - `instr_ready` 1 starting with the first cycle after reset deassertion
- Reset mid-instruction aborts it: no write-back, no `done`.

## Timing
- Cycle 0: handshake edge.
- Cycle 1: READ.
- Cycle 2: EXEC; `op_en` high for exactly this cycle.
- Cycle 3: WB; `done` high, register updated at the end of the cycle.
- Cycle 4: IDLE again, `instr_ready` = 1.
- Write-back-to-visible latency: `dbg_data` reflects the new value in cycle 4.
- Throughput: one instruction per 4 cycles with `instr_valid` held continuously.
- `result` is combinational from the units and must settle within the EXEC cycle.

## Configuration
- `ALU_ISSUE_ZERO_FLAG_EN`:
  - Defined: `zero` is registered in WB as (captured result == 4'h0) and holds until the next WB or reset.
  - Not defined: `zero` is tied to 0 and no flag register is built.

## Test plan
- Reset: assert `rst` for 2 cycles → `op_en` = 0, `done` = 0, `dbg_data` = 4'h0 for every `dbg_addr`; `instr_ready` = 1 afterwards.
- NAND: load r1 = 4'hC, r2 = 4'hA; issue op = 10, rd = 3, rs1 = 1, rs2 = 2 → `op_en` = 4'b0100 with Rd1 = C, Rd2 = A in cycle 2; r3 = 4'h7 in cycle 4; `done` pulses in cycle 3.
- Back-to-back: hold `instr_valid` with XOR r0 = r1^r2, then AND → accepted 4 cycles apart; `instr_ready` is low for 3 cycles after each accept.
- Load/instruction collision: `ld_valid` and `instr_valid` both high in IDLE → load written first; instruction accepted the next cycle and uses the new value.
- Reset in EXEC: pulse `rst` during cycle 2 → destination unchanged (reads 0 after reset), no `done`, state IDLE.
- Zero flag (macro defined): AND of r = 4'h5 with r = 4'hA → `zero` = 1 from cycle 4. Then OR of the same pair → `zero` = 0.
